// File: rtl/irrigation_zone_ctrl.sv
// Round-robin multi-zone irrigation sequencer: one valve plus the shared pump at a time.
// Define IRR_SOAK_EN to add a SOAK_CYCLES dwell (valves closed) after each watering.
module irrigation_zone_ctrl #(
    parameter int unsigned ZONES       = 4,
    parameter int unsigned SENSE_W     = 8,
    parameter int unsigned TIME_W      = 8,
    parameter int unsigned SOAK_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable_i,
    input  logic [ZONES*SENSE_W-1:0] m_sense_i,
    input  logic [SENSE_W-1:0]       l_sense_i,
    input  logic [SENSE_W-1:0]       l_thresh_i,
    input  logic [SENSE_W-1:0]       m_thresh_1_i,
    input  logic [SENSE_W-1:0]       m_thresh_2_i,
    input  logic [TIME_W-1:0]        water_time_i,
    output logic [ZONES-1:0]         valve_o,
    output logic                     pump_on_o,
    output logic [$clog2(ZONES)-1:0] active_zone_o,
    output logic [1:0]               state_o,
    output logic                     cycle_done_o
);

    localparam int unsigned ZW = $clog2(ZONES);

    localparam logic [1:0] StIdle  = 2'b00;
    localparam logic [1:0] StScan  = 2'b01;
    localparam logic [1:0] StWater = 2'b10;
    localparam logic [1:0] StSoak  = 2'b11;

    logic [1:0]         state_q, state_d;
    logic [TIME_W:0]    timer_q, timer_d;
    logic [ZW-1:0]      rr_q, rr_d;
    logic [ZW-1:0]      az_q, az_d;
    logic [ZONES-1:0]   valve_q, valve_d;
    logic               pump_q, pump_d;
    logic               done_q, done_d;

`ifdef IRR_SOAK_EN
    localparam int unsigned SW = $clog2(SOAK_CYCLES + 1);
    logic [SW-1:0]      soak_q, soak_d;
`endif

    logic [ZONES-1:0]   dry, vdry;
    logic [SENSE_W-1:0] m_z;
    logic               dark;
    logic               found;
    logic [ZW-1:0]      pick;
    logic [ZW:0]        idx;
    logic [TIME_W:0]    dur;

    assign dark = l_sense_i < l_thresh_i;

    always_comb begin
        dry  = '0;
        vdry = '0;
        m_z  = '0;
        for (int unsigned z = 0; z < ZONES; z++) begin
            m_z     = m_sense_i[z*SENSE_W +: SENSE_W];
            vdry[z] = m_z < m_thresh_2_i;
            dry[z]  = (m_z < m_thresh_1_i) | vdry[z];
        end
    end

    // First dry zone at or after the round-robin pointer, wrapping modulo ZONES.
    always_comb begin
        found = 1'b0;
        pick  = rr_q;
        idx   = '0;
        for (int unsigned i = 0; i < ZONES; i++) begin
            idx = {1'b0, rr_q} + (ZW+1)'(i);
            if (idx >= (ZW+1)'(ZONES)) idx = idx - (ZW+1)'(ZONES);
            if (!found && dry[idx[ZW-1:0]]) begin
                found = 1'b1;
                pick  = idx[ZW-1:0];
            end
        end
        dur = vdry[pick] ? {water_time_i, 1'b0} : {1'b0, water_time_i};
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        rr_d    = rr_q;
        az_d    = az_q;
        valve_d = valve_q;
        pump_d  = pump_q;
        done_d  = 1'b0;
`ifdef IRR_SOAK_EN
        soak_d  = soak_q;
`endif
        case (state_q)
            StIdle: begin
                if (enable_i && dark) state_d = StScan;
            end
            StScan: begin
                if (enable_i && dark && found && (dur != '0)) begin
                    state_d       = StWater;
                    az_d          = pick;
                    timer_d       = dur;
                    valve_d       = '0;
                    valve_d[pick] = 1'b1;
                    pump_d        = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            StWater: begin
                if (!enable_i) begin
                    state_d = StIdle;
                    timer_d = '0;
                    valve_d = '0;
                    pump_d  = 1'b0;
                end else begin
                    timer_d = timer_q - 1'b1;
                    if (timer_q == (TIME_W+1)'(1)) begin
                        valve_d = '0;
                        pump_d  = 1'b0;
                        done_d  = 1'b1;
                        rr_d    = (az_q == ZW'(ZONES - 1)) ? '0 : az_q + 1'b1;
`ifdef IRR_SOAK_EN
                        state_d = StSoak;
                        soak_d  = SW'(SOAK_CYCLES - 1);
`else
                        state_d = StScan;
`endif
                    end
                end
            end
            StSoak: begin
`ifdef IRR_SOAK_EN
                if (!enable_i) state_d = StIdle;
                else if (soak_q == '0) state_d = StScan;
                else soak_d = soak_q - 1'b1;
`else
                state_d = StIdle;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            timer_q <= '0;
            rr_q    <= '0;
            az_q    <= '0;
            valve_q <= '0;
            pump_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef IRR_SOAK_EN
            soak_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            rr_q    <= rr_d;
            az_q    <= az_d;
            valve_q <= valve_d;
            pump_q  <= pump_d;
            done_q  <= done_d;
`ifdef IRR_SOAK_EN
            soak_q  <= soak_d;
`endif
        end
    end

    assign valve_o       = valve_q;
    assign pump_on_o     = pump_q;
    assign active_zone_o = az_q;
    assign state_o       = state_q;
    assign cycle_done_o  = done_q;

endmodule

// File: tb/tb_irrigation_zone_ctrl.sv
// Randomized bench for irrigation_zone_ctrl against a watering-schedule model.
// Honours IRR_SOAK_EN for the expected inter-watering gap.
module tb_irrigation_zone_ctrl;

    localparam int unsigned SOAK = 16;
    localparam int M1 = 150;
    localparam int M2 = 100;
    localparam int LT = 64;
`ifdef IRR_SOAK_EN
    localparam int EXP_GAP = SOAK + 1;
    localparam bit SOAK_ON = 1'b1;
`else
    localparam int EXP_GAP = 1;
    localparam bit SOAK_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic [7:0]  m_arr [4];
    logic [7:0]  l_sense = 8'd200;
    logic [7:0]  wt = 8'd5;
    logic [31:0] m_sense;
    logic [3:0]  valve;
    logic        pump_on;
    logic [1:0]  active_zone;
    logic [1:0]  state;
    logic        cycle_done;

    int n_cmp = 0;
    int n_bad = 0;
    int mrr = 0;

    assign m_sense = {m_arr[3], m_arr[2], m_arr[1], m_arr[0]};

    always #5 clk = ~clk;

    irrigation_zone_ctrl #(
        .ZONES(4), .SENSE_W(8), .TIME_W(8), .SOAK_CYCLES(SOAK)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable_i     (enable),
        .m_sense_i    (m_sense),
        .l_sense_i    (l_sense),
        .l_thresh_i   (8'(LT)),
        .m_thresh_1_i (8'(M1)),
        .m_thresh_2_i (8'(M2)),
        .water_time_i (wt),
        .valve_o      (valve),
        .pump_on_o    (pump_on),
        .active_zone_o(active_zone),
        .state_o      (state),
        .cycle_done_o (cycle_done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input logic [7:0] v);
        for (int i = 0; i < 4; i++) m_arr[i] = v;
    endtask

    // Watering length the schedule calls for; 0 means the zone is not due.
    function automatic int dur_of(input int z);
        if (int'(m_arr[z]) < M2) return 2 * int'(wt);
        if (int'(m_arr[z]) < M1) return int'(wt);
        return 0;
    endfunction

    function automatic int next_zone();
        for (int k = 0; k < 4; k++) begin
            if (dur_of((mrr + k) % 4) > 0) return (mrr + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [7:0] m_pick();
        int r;
        r = int'($urandom_range(0, 9));
        case (r)
            0: return 8'd99;
            1: return 8'd100;
            2: return 8'd149;
            3: return 8'd150;
            4, 5: return 8'($urandom_range(0, 98));
            6, 7: return 8'($urandom_range(101, 148));
            default: return 8'($urandom_range(151, 255));
        endcase
    endfunction

    // Make every zone wet and the light bright, then expect the block to settle idle.
    task automatic park(input bit chk_valve);
        set_all(8'd255);
        l_sense = 8'd200;
        enable  = 1'b1;
        repeat (SOAK + 4) begin
            tick();
            if (chk_valve) check_eq("park_valve", 32'(valve), 0);
        end
        check_eq("park_state", 32'(state), 0);
    endtask

    task automatic episode(input int nb, input int ab_burst, input int ab_at,
                           input logic [7:0] l, input logic en);
        int z, d, len, gap, guard;
        bit soak_seen, aborted;
        l_sense = l;
        enable  = en;
        if (!en || int'(l) >= LT || next_zone() < 0) begin
            repeat (12) begin
                tick();
                check_eq("quiet_valve", 32'(valve), 0);
                check_eq("quiet_pump", 32'(pump_on), 0);
            end
            park(1'b0);
            return;
        end
        gap = 0;
        soak_seen = 1'b0;
        z = 0;
        for (int b = 0; b < nb; b++) begin
            z = next_zone();
            d = dur_of(z);
            guard = 0;
            tick();
            while (valve == 4'd0 && guard < 60) begin
                gap++;
                guard++;
                if (state == 2'b11) soak_seen = 1'b1;
                check_eq("done_single", 32'(cycle_done), 0);
                tick();
            end
            if (guard >= 60) begin
                check_eq("burst_start", 0, 1);
                park(1'b0);
                return;
            end
            if (b > 0) begin
                check_eq("gap_len", gap, EXP_GAP);
                check_eq("soak_state", 32'(soak_seen), 32'(SOAK_ON));
            end
            len = 0;
            aborted = 1'b0;
            while (valve != 4'd0 && len < 64) begin
                len++;
                check_eq("valve_onehot", 32'(valve), 1 << z);
                check_eq("pump", 32'(pump_on), 1);
                check_eq("zone", 32'(active_zone), z);
                check_eq("state_water", 32'(state), 2);
                if (b == ab_burst && len == ab_at && ab_at < d) begin
                    enable  = 1'b0;
                    aborted = 1'b1;
                end
                tick();
            end
            if (aborted) begin
                check_eq("abort_len", len, ab_at);
                check_eq("abort_state", 32'(state), 0);
                check_eq("abort_no_done", 32'(cycle_done), 0);
                check_eq("abort_pump", 32'(pump_on), 0);
                park(1'b1);
                check_eq("abort_zone", 32'(active_zone), z);
                return;
            end
            check_eq("burst_len", len, d);
            check_eq("done_pulse", 32'(cycle_done), 1);
            check_eq("post_state", 32'(state), SOAK_ON ? 3 : 1);
            mrr = (z + 1) % 4;
            gap = 1;
            soak_seen = (state == 2'b11);
        end
        park(1'b1);
        check_eq("hold_zone", 32'(active_zone), z);
    endtask

    initial begin
        int guard;
        int r, nb, ab;
        logic [7:0] l;
        logic en;

        set_all(8'd255);
        repeat (3) tick();
        check_eq("rst_valve", 32'(valve), 0);
        check_eq("rst_pump", 32'(pump_on), 0);
        check_eq("rst_state", 32'(state), 0);
        check_eq("rst_done", 32'(cycle_done), 0);
        check_eq("rst_zone", 32'(active_zone), 0);
        rst_n = 1'b1;
        repeat (20) begin
            tick();
            check_eq("bright_state", 32'(state), 0);
            check_eq("bright_valve", 32'(valve), 0);
            check_eq("bright_pump", 32'(pump_on), 0);
        end

        set_all(8'd255); m_arr[2] = 8'd120;
        episode(1, -1, 0, 8'd10, 1'b1);
        set_all(8'd255); m_arr[1] = 8'd50;
        episode(1, -1, 0, 8'd10, 1'b1);
        set_all(8'd255); m_arr[0] = 8'd120; m_arr[3] = 8'd120;
        episode(5, -1, 0, 8'd10, 1'b1);
        set_all(8'd255); m_arr[0] = 8'd50;
        episode(1, 0, 3, 8'd10, 1'b1);

        // Asynchronous reset in the middle of a watering burst.
        set_all(8'd255); m_arr[1] = 8'd50;
        l_sense = 8'd10;
        guard = 0;
        while (valve == 4'd0 && guard < 20) begin
            tick();
            guard++;
        end
        check_eq("rst_burst_seen", 32'(guard < 20), 1);
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        check_eq("async_valve", 32'(valve), 0);
        check_eq("async_pump", 32'(pump_on), 0);
        check_eq("async_state", 32'(state), 0);
        check_eq("async_zone", 32'(active_zone), 0);
        tick();
        rst_n = 1'b1;
        mrr = 0;
        park(1'b1);

        set_all(8'd255); m_arr[0] = 8'd120; m_arr[3] = 8'd120;
        episode(4, -1, 0, 8'd10, 1'b1);
        set_all(8'd255); m_arr[1] = 8'd50; wt = 8'd0;
        episode(1, -1, 0, 8'd10, 1'b1);
        wt = 8'd5;
        set_all(8'd255); m_arr[2] = 8'd120;
        episode(1, -1, 0, 8'd64, 1'b1);
        episode(1, -1, 0, 8'd10, 1'b0);

        for (int e = 0; e < 30; e++) begin
            for (int i = 0; i < 4; i++) m_arr[i] = m_pick();
            wt = 8'($urandom_range(0, 6));
            r = int'($urandom_range(0, 9));
            if (r == 0) l = 8'd64;
            else if (r == 1) l = 8'd63;
            else if (r < 8) l = 8'($urandom_range(0, 62));
            else l = 8'($urandom_range(65, 255));
            en = ($urandom_range(0, 9) != 0);
            nb = int'($urandom_range(1, 4));
            ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
            episode(nb, ab, int'($urandom_range(1, 3)), l, en);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
